lpif_txrx_asym_slave_buf: RTL and testbench

- Parametrised successor to the fixed-width LPIF slave-side field packer. It packs and unpacks the LPIF upstream and downstream field bundles to and from the logic-link FIFO word.
- Adds a buffered upstream path: a DEPTH-entry FIFO with valid/ready toward the TX logic link, gen1 half-rate pacing and overflow tracking.
- Adds a registered downstream stage with beat gating.
- Sits between the LPIF slave user logic and the TX/RX logic-link FIFOs of the asymmetric AIB channel.

---
 rtl/lpif_txrx_asym_slave_buf.sv | 128 ++++++++++++
 tb/tb_lpif_txrx_asym_slave_buf.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpif_txrx_asym_slave_buf.sv
// LPIF slave-side packer with a buffered, paced upstream path toward the TX
// logic link and a registered, beat-gated downstream unpack from the RX link.
module lpif_txrx_asym_slave_buf #(
   parameter  int DATA_WIDTH = 128,
   parameter  int CRC_WIDTH  = 8,
   parameter  int DEPTH      = 4,
   localparam int PKT_WIDTH  = DATA_WIDTH + CRC_WIDTH + 9,
   localparam int AW         = $clog2(DEPTH),
   localparam int LW         = $clog2(DEPTH) + 1
) (
   input  logic                  clk_wr,
   input  logic                  rst_wr_n,
   input  logic                  m_gen2_mode,
   input  logic [3:0]            ustrm_state,
   input  logic [1:0]            ustrm_protid,
   input  logic [DATA_WIDTH-1:0] ustrm_data,
   input  logic                  ustrm_dvalid,
   input  logic [CRC_WIDTH-1:0]  ustrm_crc,
   input  logic                  ustrm_crc_valid,
   input  logic                  ustrm_valid,
   output logic [PKT_WIDTH-1:0]  txfifo_upstream_data,
   output logic                  txfifo_upstream_vld,
   input  logic                  txfifo_upstream_rdy,
   input  logic [PKT_WIDTH-1:0]  rxfifo_downstream_data,
   input  logic                  rxfifo_downstream_vld,
   output logic [3:0]            dstrm_state,
   output logic [1:0]            dstrm_protid,
   output logic [DATA_WIDTH-1:0] dstrm_data,
   output logic                  dstrm_dvalid,
   output logic [CRC_WIDTH-1:0]  dstrm_crc,
   output logic                  dstrm_crc_valid,
   output logic                  dstrm_valid,
   output logic                  tx_overflow,
   output logic [7:0]            tx_drop_cnt,
   output logic [LW-1:0]         tx_level
);

   localparam int O_DATA = 6;
   localparam int O_DV   = 6 + DATA_WIDTH;
   localparam int O_CRC  = 7 + DATA_WIDTH;
   localparam int O_CV   = 7 + DATA_WIDTH + CRC_WIDTH;
   localparam int O_V    = 8 + DATA_WIDTH + CRC_WIDTH;

   logic [PKT_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]        r_level;
   logic                 r_tog, r_gen2, r_ovf;
   logic [7:0]           r_drop;

   logic [PKT_WIDTH-1:0] w_word;
   logic                 w_full, w_pace, w_vld, w_pop, w_push, w_drop;

   assign w_word = {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
                    ustrm_data, ustrm_protid, ustrm_state};

   // Gen1 pacing: the toggle gates the head every other cycle; the mode input
   // is registered so a change only lands on the following cycle.
   assign w_full = (r_level == LW'(DEPTH));
   assign w_pace = r_gen2 | ~r_tog;
   assign w_vld  = (r_level != '0) & w_pace;
   assign w_pop  = w_vld & txfifo_upstream_rdy;
   assign w_push = ustrm_valid & (~w_full | w_pop);
   assign w_drop = ustrm_valid & w_full & ~w_pop;

   assign txfifo_upstream_data = r_mem[r_rd_ptr];
   assign txfifo_upstream_vld  = w_vld;
   assign tx_level             = r_level;
   assign tx_overflow          = r_ovf;
   assign tx_drop_cnt          = r_drop;

   always_ff @(posedge clk_wr) begin
      if (w_push) r_mem[r_wr_ptr] <= w_word;
   end

   always_ff @(posedge clk_wr) begin
      r_gen2 <= m_gen2_mode;
   end

   always_ff @(posedge clk_wr) begin
      if (!rst_wr_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_tog    <= 1'b0;
         r_ovf    <= 1'b0;
         r_drop   <= '0;
      end else begin
         r_tog <= ~r_tog;
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
         end
      end
   end

   // Qualifiers drop on idle cycles; payload fields keep the last beat.
   always_ff @(posedge clk_wr) begin
      if (!rst_wr_n) begin
         dstrm_state     <= '0;
         dstrm_protid    <= '0;
         dstrm_data      <= '0;
         dstrm_dvalid    <= 1'b0;
         dstrm_crc       <= '0;
         dstrm_crc_valid <= 1'b0;
         dstrm_valid     <= 1'b0;
      end else if (rxfifo_downstream_vld) begin
         dstrm_state     <= rxfifo_downstream_data[3:0];
         dstrm_protid    <= rxfifo_downstream_data[5:4];
         dstrm_data      <= rxfifo_downstream_data[O_DATA +: DATA_WIDTH];
         dstrm_dvalid    <= rxfifo_downstream_data[O_DV];
         dstrm_crc       <= rxfifo_downstream_data[O_CRC +: CRC_WIDTH];
         dstrm_crc_valid <= rxfifo_downstream_data[O_CV];
         dstrm_valid     <= rxfifo_downstream_data[O_V];
      end else begin
         dstrm_dvalid    <= 1'b0;
         dstrm_crc_valid <= 1'b0;
         dstrm_valid     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lpif_txrx_asym_slave_buf.sv
// Randomized bench for lpif_txrx_asym_slave_buf: queue-based reference model of
// the upstream buffer/pacing and the downstream register, plus a 256-bit loopback.
module tb_lpif_txrx_asym_slave_buf;
   localparam int DW = 128, CW = 8, DEPTH = 4, PW = DW + CW + 9, LW = 3;
   localparam int DW2 = 256, PW2 = DW2 + CW + 9;

   logic clk_wr = 1'b0;
   always #5 clk_wr = ~clk_wr;

   logic           rst_wr_n, m_gen2_mode;
   logic [3:0]     ustrm_state;
   logic [1:0]     ustrm_protid;
   logic [DW-1:0]  ustrm_data;
   logic [DW2-1:0] ustrm_data_2;
   logic           ustrm_dvalid, ustrm_crc_valid, ustrm_valid;
   logic [CW-1:0]  ustrm_crc;
   logic [PW-1:0]  txfifo_upstream_data, rxfifo_downstream_data;
   logic           txfifo_upstream_vld, txfifo_upstream_rdy, rxfifo_downstream_vld;
   logic [3:0]     dstrm_state;
   logic [1:0]     dstrm_protid;
   logic [DW-1:0]  dstrm_data;
   logic [CW-1:0]  dstrm_crc;
   logic           dstrm_dvalid, dstrm_crc_valid, dstrm_valid, tx_overflow;
   logic [7:0]     tx_drop_cnt;
   logic [LW-1:0]  tx_level;

   logic [PW2-1:0] tx_data_2;
   logic           tx_vld_2, dstrm_dvalid_2, dstrm_crc_valid_2, dstrm_valid_2, tx_overflow_2;
   logic [3:0]     dstrm_state_2;
   logic [1:0]     dstrm_protid_2;
   logic [DW2-1:0] dstrm_data_2;
   logic [CW-1:0]  dstrm_crc_2;
   logic [7:0]     tx_drop_cnt_2;
   logic [LW-1:0]  tx_level_2;

   lpif_txrx_asym_slave_buf #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .DEPTH(DEPTH)) u_dut (
      .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .m_gen2_mode(m_gen2_mode),
      .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid), .ustrm_data(ustrm_data),
      .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc), .ustrm_crc_valid(ustrm_crc_valid),
      .ustrm_valid(ustrm_valid), .txfifo_upstream_data(txfifo_upstream_data),
      .txfifo_upstream_vld(txfifo_upstream_vld), .txfifo_upstream_rdy(txfifo_upstream_rdy),
      .rxfifo_downstream_data(rxfifo_downstream_data), .rxfifo_downstream_vld(rxfifo_downstream_vld),
      .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
      .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
      .dstrm_valid(dstrm_valid), .tx_overflow(tx_overflow), .tx_drop_cnt(tx_drop_cnt),
      .tx_level(tx_level));

   // Wide build looped back on itself: TX head feeds its own RX register.
   lpif_txrx_asym_slave_buf #(.DATA_WIDTH(DW2), .CRC_WIDTH(CW), .DEPTH(DEPTH)) u_dut_2 (
      .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .m_gen2_mode(1'b1),
      .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid), .ustrm_data(ustrm_data_2),
      .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc), .ustrm_crc_valid(ustrm_crc_valid),
      .ustrm_valid(ustrm_valid), .txfifo_upstream_data(tx_data_2),
      .txfifo_upstream_vld(tx_vld_2), .txfifo_upstream_rdy(1'b1),
      .rxfifo_downstream_data(tx_data_2), .rxfifo_downstream_vld(tx_vld_2),
      .dstrm_state(dstrm_state_2), .dstrm_protid(dstrm_protid_2), .dstrm_data(dstrm_data_2),
      .dstrm_dvalid(dstrm_dvalid_2), .dstrm_crc(dstrm_crc_2), .dstrm_crc_valid(dstrm_crc_valid_2),
      .dstrm_valid(dstrm_valid_2), .tx_overflow(tx_overflow_2), .tx_drop_cnt(tx_drop_cnt_2),
      .tx_level(tx_level_2));

   int n_tot = 0, n_bad = 0;

   logic [PW-1:0] mq[$];
   bit            m_ovf, m_g2, m_init, m_rxv;
   int            m_drop, m_cyc;
   logic [PW-1:0] m_rxw;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] mk_word();
      return {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid, ustrm_data,
              ustrm_protid, ustrm_state};
   endfunction

   task automatic rnd_beat(input bit v);
      ustrm_state     = 4'($urandom);
      ustrm_protid    = 2'($urandom);
      ustrm_data      = {$urandom, $urandom, $urandom, $urandom};
      ustrm_dvalid    = 1'($urandom);
      ustrm_crc       = CW'($urandom);
      ustrm_crc_valid = 1'($urandom);
      ustrm_valid     = v;
      for (int i = 0; i < 8; i++) ustrm_data_2[i*32 +: 32] = $urandom;
   endtask

   // Check outputs against the model, advance the model by one clock, then clock.
   task automatic step();
      bit e_vld, pop;
      e_vld = (mq.size() != 0) && (m_g2 || (m_cyc % 2 == 0));
      if (m_init) begin
         chk("vld", txfifo_upstream_vld, e_vld);
         if (mq.size() != 0) chk("head", txfifo_upstream_data, mq[0]);
         chk("level", tx_level, mq.size());
         chk("ovf", tx_overflow, m_ovf);
         chk("drop", tx_drop_cnt, m_drop);
         chk("rx_state", dstrm_state, m_rxw[3:0]);
         chk("rx_protid", dstrm_protid, m_rxw[5:4]);
         chk("rx_data", dstrm_data, m_rxw[6 +: DW]);
         chk("rx_dvalid", dstrm_dvalid, m_rxv & m_rxw[6+DW]);
         chk("rx_crc", dstrm_crc, m_rxw[7+DW +: CW]);
         chk("rx_cv", dstrm_crc_valid, m_rxv & m_rxw[7+DW+CW]);
         chk("rx_valid", dstrm_valid, m_rxv & m_rxw[8+DW+CW]);
      end
      if (!rst_wr_n) begin
         mq.delete();
         m_ovf = 0; m_drop = 0; m_cyc = 0; m_rxw = '0; m_rxv = 0; m_init = 1;
      end else begin
         pop = e_vld && txfifo_upstream_rdy;
         if (pop) void'(mq.pop_front());
         if (ustrm_valid) begin
            if (mq.size() == DEPTH) begin
               m_ovf = 1;
               if (m_drop < 255) m_drop++;
            end else mq.push_back(mk_word());
         end
         m_cyc++;
         if (rxfifo_downstream_vld) begin m_rxw = rxfifo_downstream_data; m_rxv = 1; end
         else m_rxv = 0;
      end
      m_g2 = m_gen2_mode;
      @(posedge clk_wr); #1;
   endtask

   task automatic do_reset();
      rst_wr_n = 1'b0; step(); rst_wr_n = 1'b1;
   endtask

   logic [PW-1:0] saved[$];
   logic [PW-1:0] rw;
   int n_pop, n_back;
   bit prev_vld;
   logic [DW2-1:0] s_data2;
   logic [3:0] s_state; logic [1:0] s_prot; logic [CW-1:0] s_crc; bit s_dv, s_cv;

   initial begin
      m_init = 0; m_ovf = 0; m_drop = 0; m_cyc = 0; m_rxw = '0; m_rxv = 0; m_g2 = 1;
      m_gen2_mode = 1; txfifo_upstream_rdy = 1; rxfifo_downstream_vld = 0;
      rxfifo_downstream_data = '0; rnd_beat(0);
      rst_wr_n = 0; step(); step(); rst_wr_n = 1;
      chk("rst_vld", txfifo_upstream_vld, 0);
      chk("rst_level", tx_level, 0);
      chk("rst_ovf", tx_overflow, 0);
      chk("rst_drop", tx_drop_cnt, 0);
      chk("rst_dvalid", dstrm_valid, 0);
      chk("rst_ddata", dstrm_data, 0);

      // Single directed beat.
      ustrm_state = 4'h3; ustrm_protid = 2'b01; ustrm_data = {16{8'hA5}};
      ustrm_dvalid = 1; ustrm_crc = 8'h5C; ustrm_crc_valid = 1; ustrm_valid = 1;
      step();
      ustrm_valid = 0;
      chk("s1_vld", txfifo_upstream_vld, 1);
      rw = txfifo_upstream_data;
      chk("s1_bit144", rw[144], 1);
      chk("s1_crc", rw[142:135], 8'h5C);
      chk("s1_data", rw[133:6], {16{8'hA5}});
      step();
      chk("s1_level0", tx_level, 0);

      // Overflow with rdy held low, then in-order drain.
      txfifo_upstream_rdy = 0; saved.delete();
      for (int i = 0; i < 6; i++) begin rnd_beat(1); saved.push_back(mk_word()); step(); end
      ustrm_valid = 0;
      chk("s2_level", tx_level, 4);
      chk("s2_ovf", tx_overflow, 1);
      chk("s2_drop", tx_drop_cnt, 2);
      txfifo_upstream_rdy = 1;
      for (int i = 0; i < 4; i++) begin
         chk("s2_drain_vld", txfifo_upstream_vld, 1);
         chk("s2_drain_data", txfifo_upstream_data, saved[i]);
         step();
      end
      chk("s2_empty", txfifo_upstream_vld, 0);

      // Gen1 half-rate pacing.
      m_gen2_mode = 0; do_reset();
      n_pop = 0; n_back = 0; prev_vld = 0;
      for (int i = 0; i < 10; i++) begin
         rnd_beat(i < 4);
         if (txfifo_upstream_vld) n_pop++;
         if (txfifo_upstream_vld && prev_vld) n_back++;
         prev_vld = txfifo_upstream_vld;
         step();
      end
      ustrm_valid = 0;
      chk("s3_pops", n_pop, 4);
      chk("s3_b2b", n_back, 0);
      chk("s3_drop", tx_drop_cnt, 0);

      // Full buffer, simultaneous write and pop.
      m_gen2_mode = 1; txfifo_upstream_rdy = 0;
      for (int i = 0; i < 4; i++) begin rnd_beat(1); step(); end
      txfifo_upstream_rdy = 1; rnd_beat(1); step();
      ustrm_valid = 0;
      chk("s4_level", tx_level, 4);
      chk("s4_drop", tx_drop_cnt, 0);
      for (int i = 0; i < 5; i++) step();

      // RX load then idle.
      for (int i = 0; i < 5; i++) rw[i*32 +: 32] = $urandom;
      rw[PW-1] = 1; rw[6+DW] = 1;
      rxfifo_downstream_data = rw; rxfifo_downstream_vld = 1; step();
      chk("s5_data", dstrm_data, rw[6 +: DW]);
      chk("s5_valid", dstrm_valid, 1);
      rxfifo_downstream_vld = 0; rxfifo_downstream_data = '0; step();
      chk("s5_idle_valid", dstrm_valid, 0);
      chk("s5_idle_dvalid", dstrm_dvalid, 0);
      chk("s5_hold", dstrm_data, rw[6 +: DW]);

      // Reset with beats buffered.
      txfifo_upstream_rdy = 0;
      for (int i = 0; i < 3; i++) begin rnd_beat(1); step(); end
      ustrm_valid = 0;
      chk("s6_level3", tx_level, 3);
      do_reset();
      chk("s6_vld", txfifo_upstream_vld, 0);
      chk("s6_level", tx_level, 0);
      chk("s6_ddata", dstrm_data, 0);
      chk("s6_dstate", dstrm_state, 0);

      // Random traffic against the model.
      for (int i = 0; i < 500; i++) begin
         rnd_beat(($urandom % 3) != 0);
         txfifo_upstream_rdy = 1'($urandom);
         if (($urandom % 16) == 0) m_gen2_mode = ~m_gen2_mode;
         rxfifo_downstream_vld = 1'($urandom);
         for (int j = 0; j < 5; j++) rw[j*32 +: 32] = $urandom;
         rxfifo_downstream_data = rw;
         rst_wr_n = (($urandom % 100) != 0);
         step();
      end
      rst_wr_n = 1; txfifo_upstream_rdy = 1; rxfifo_downstream_vld = 0;

      // 256-bit build loopback.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         rnd_beat(1);
         s_data2 = ustrm_data_2; s_state = ustrm_state; s_prot = ustrm_protid;
         s_crc = ustrm_crc; s_dv = ustrm_dvalid; s_cv = ustrm_crc_valid;
         step();
         chk("lb_idle", dstrm_valid_2, 0);
         ustrm_valid = 0;
         step();
         chk("lb_valid", dstrm_valid_2, 1);
         chk("lb_data", dstrm_data_2, s_data2);
         chk("lb_state", dstrm_state_2, s_state);
         chk("lb_protid", dstrm_protid_2, s_prot);
         chk("lb_crc", dstrm_crc_2, s_crc);
         chk("lb_dvalid", dstrm_dvalid_2, s_dv);
         chk("lb_cv", dstrm_crc_valid_2, s_cv);
      end
      chk("lb_drop", tx_drop_cnt_2, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
